wash_cycle_ctrl: RTL and testbench

//   Parametrised washing-machine cycle controller: N selectable modes, each with
//   its own duration and price, a prepaid balance, pause/resume, cancel and an

---
 rtl/wash_pkg.sv | 11 +
 rtl/wash_tick_gen.sv | 19 +
 rtl/wash_cycle_ctrl.sv | 141 ++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// wash_pkg: shared state encoding and prescaler defaults for the wash controller
package wash_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_t;
    localparam int TICK_DIV_SYN = 100_000_000;
    localparam int TICK_DIV_SIM = 4;
endpackage

// File: rtl/wash_tick_gen.sv
// wash_tick_gen: 1 s tick prescaler with count enable and synchronous clear
//   clk, rst(async, active-low) | en: count | clr: restart from 0 | tick: count==TICK_DIV-1
module wash_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: prepaid multi-mode wash cycle FSM with pause, cancel and uncollected fine
//   in : clk, rst(async, active-low), start/cancel/collect/credit_vld pulses,
//        mode_sel, packed mode_time/mode_price tables, credit_amt
//   out: state, remaining_s, balance, done/err pulses, fine_flag (sticky)
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_SYN,
    parameter int N_MODES    = 4,
    parameter int TIME_W     = 8,
    parameter int PRICE_W    = 9,
    parameter int BAL_W      = 10,
    parameter int FINE_GRACE = 30,
    parameter int FINE_AMT   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cancel,
    input  logic                         collect,
    input  logic [$clog2(N_MODES)-1:0]   mode_sel,
    input  logic [N_MODES*TIME_W-1:0]    mode_time,
    input  logic [N_MODES*PRICE_W-1:0]   mode_price,
    input  logic                         credit_vld,
    input  logic [BAL_W-1:0]             credit_amt,
    output logic [2:0]                   state,
    output logic [TIME_W-1:0]            remaining_s,
    output logic [BAL_W-1:0]             balance,
    output logic                         done,
    output logic                         err,
    output logic                         fine_flag
);
    localparam int GW = $clog2(FINE_GRACE + 1);
    localparam logic [BAL_W-1:0] FINE = BAL_W'(FINE_AMT);

    state_t              state_q, state_n;
    logic [TIME_W-1:0]   rem_n;
    logic [GW-1:0]       grace, grace_n;
    logic [BAL_W-1:0]    debit, credit, fine_debit, bal_n;
    logic [BAL_W:0]      sum;
    logic                done_n, err_n, fine_n, tick, afford;
    logic [TIME_W-1:0]   times  [N_MODES];
    logic [PRICE_W-1:0]  prices [N_MODES];

    for (genvar i = 0; i < N_MODES; i++) begin : g_unpack
        assign times[i]  = mode_time[i*TIME_W +: TIME_W];
        assign prices[i] = mode_price[i*PRICE_W +: PRICE_W];
    end

    wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN || state_q == ST_DONE),
        .clr  (state_n != state_q),
        .tick (tick)
    );

    // Affordability deliberately uses the pre-credit balance.
    assign afford     = int'(mode_sel) < N_MODES && BAL_W'(prices[mode_sel]) <= balance;
    assign fine_debit = balance >= FINE ? FINE : balance;
    assign credit     = credit_vld ? credit_amt : '0;
    // Debit never exceeds the old balance, so only the upper bound can overflow.
    assign sum        = {1'b0, balance} + {1'b0, credit} - {1'b0, debit};
    assign bal_n      = sum[BAL_W] ? '1 : sum[BAL_W-1:0];
    assign state      = state_q;

    always_comb begin
        state_n = state_q;
        rem_n   = remaining_s;
        grace_n = grace;
        fine_n  = fine_flag;
        debit   = '0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            ST_IDLE:
                if (start && afford) begin
                    state_n = ST_RUN;
                    rem_n   = times[mode_sel];
                    debit   = BAL_W'(prices[mode_sel]);
                end else if (start) err_n = 1'b1;
            ST_RUN:
                if (cancel) begin
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else if (start) state_n = ST_PAUSE;
                else if (remaining_s == '0) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else if (tick) begin
                    rem_n = remaining_s - TIME_W'(1);
                    if (remaining_s == TIME_W'(1)) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
            ST_PAUSE:
                if (cancel) begin
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else if (start) state_n = ST_RUN;
            ST_DONE:
                if (collect) begin
                    state_n = ST_IDLE;
                    grace_n = '0;
                    fine_n  = 1'b0;
                end else if (tick && grace != GW'(FINE_GRACE)) begin
                    // The counter saturates at the grace limit, so the fine is charged once.
                    grace_n = grace + GW'(1);
                    if (grace == GW'(FINE_GRACE - 1)) begin
                        fine_n = 1'b1;
                        debit  = fine_debit;
                    end
                end
            default: begin
                state_n = ST_IDLE;
                rem_n   = '0;
                grace_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_s <= '0;
            balance     <= '0;
            grace       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            fine_flag   <= 1'b0;
        end else begin
            state_q     <= state_n;
            remaining_s <= rem_n;
            balance     <= bal_n;
            grace       <= grace_n;
            done        <= done_n;
            err         <= err_n;
            fine_flag   <= fine_n;
        end
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb_wash_cycle_ctrl: scoreboard bench for the wash cycle controller (sim tick divider)
module tb_wash_cycle_ctrl;
    import wash_pkg::*;

    localparam int BAL_W = 10;

    logic             clk = 0, rst = 1;
    logic             start = 0, cancel = 0, collect = 0, credit_vld = 0;
    logic [1:0]       mode_sel = 0;
    logic [31:0]      mode_time  = {8'd5, 8'd3, 8'd2, 8'd1};
    logic [35:0]      mode_price = {9'd30, 9'd12, 9'd5, 9'd3};
    logic [BAL_W-1:0] credit_amt = 0;
    logic [2:0]       state;
    logic [7:0]       remaining_s;
    logic [BAL_W-1:0] balance;
    logic             done, err, fine_flag;

    wash_cycle_ctrl #(
        .TICK_DIV(TICK_DIV_SIM), .N_MODES(4), .TIME_W(8), .PRICE_W(9),
        .BAL_W(BAL_W), .FINE_GRACE(3), .FINE_AMT(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .collect(collect),
        .mode_sel(mode_sel), .mode_time(mode_time), .mode_price(mode_price),
        .credit_vld(credit_vld), .credit_amt(credit_amt), .state(state),
        .remaining_s(remaining_s), .balance(balance), .done(done), .err(err),
        .fine_flag(fine_flag)
    );

    always #5 clk = ~clk;

    typedef enum int {SG_STATE, SG_REM, SG_BAL, SG_DONE, SG_ERR, SG_FINE} sig_t;
    typedef struct {
        string       tag;
        sig_t        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_t s);
        case (s)
            SG_STATE: return 32'(state);
            SG_REM:   return 32'(remaining_s);
            SG_BAL:   return 32'(balance);
            SG_DONE:  return 32'(done);
            SG_ERR:   return 32'(err);
            default:  return 32'(fine_flag);
        endcase
    endfunction

    task automatic push(input string tag, input sig_t s, input int v);
        sb.push_back('{tag, s, 32'(v)});
    endtask

    task automatic want(input string tag, input state_t st, input int rem, input int bal);
        push({tag, ".state"}, SG_STATE, int'(st));
        push({tag, ".rem"}, SG_REM, rem);
        push({tag, ".bal"}, SG_BAL, bal);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic cyc(input logic s, input logic ca, input logic co, input logic cv,
                       input int amt, input int m);
        start = s; cancel = ca; collect = co; credit_vld = cv;
        credit_amt = BAL_W'(amt); mode_sel = 2'(m);
        @(negedge clk);
        start = 0; cancel = 0; collect = 0; credit_vld = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic want_reset(input string tag);
        want(tag, ST_IDLE, 0, 0);
        push({tag, ".done"}, SG_DONE, 0);
        push({tag, ".err"}, SG_ERR, 0);
        push({tag, ".fine"}, SG_FINE, 0);
        drain();
    endtask

    initial begin
        #1 rst = 0;
        idle(2);
        want_reset("reset");
        rst = 1;
        idle(1);

        // paid cycle: mode 2, 3 s, price 12
        cyc(0, 0, 0, 1, 20, 0); want("credit20", ST_IDLE, 0, 20); drain();
        cyc(1, 0, 0, 0, 0, 2);  want("start_m2", ST_RUN, 3, 8); drain();
        idle(11); want("run_last", ST_RUN, 1, 8); push("run_last.done", SG_DONE, 0); drain();
        idle(1);  want("enter_done", ST_DONE, 0, 8); push("enter_done.done", SG_DONE, 1); drain();
        idle(1);  push("done_pulse_end", SG_DONE, 0); drain();

        // uncollected fine after 3 ticks in DONE
        idle(10); want("pre_fine", ST_DONE, 0, 8); push("pre_fine.flag", SG_FINE, 0); drain();
        idle(1);  want("fine", ST_DONE, 0, 3); push("fine.flag", SG_FINE, 1); drain();
        idle(12); want("no_refine", ST_DONE, 0, 3); push("no_refine.flag", SG_FINE, 1); drain();
        cyc(1, 1, 0, 0, 0, 0); want("done_ign", ST_DONE, 0, 3); drain();
        cyc(0, 0, 1, 0, 0, 0); want("collect", ST_IDLE, 0, 3); push("collect.flag", SG_FINE, 0); drain();

        // unaffordable start
        cyc(1, 0, 0, 0, 0, 2); want("poor", ST_IDLE, 0, 3); push("poor.err", SG_ERR, 1); drain();
        idle(1); push("poor.err_end", SG_ERR, 0); drain();

        // pause / resume
        cyc(0, 0, 0, 1, 17, 0); want("credit17", ST_IDLE, 0, 20); drain();
        cyc(1, 0, 0, 0, 0, 2);  want("start2", ST_RUN, 3, 8); drain();
        idle(4);                want("one_tick", ST_RUN, 2, 8); drain();
        cyc(1, 0, 0, 0, 0, 0);  want("pause", ST_PAUSE, 2, 8); drain();
        idle(20);               want("paused", ST_PAUSE, 2, 8); drain();
        cyc(1, 0, 0, 0, 0, 0);  want("resume", ST_RUN, 2, 8); drain();
        idle(7);                want("resume_last", ST_RUN, 1, 8); drain();
        idle(1); want("resume_done", ST_DONE, 0, 8); push("resume_done.done", SG_DONE, 1); drain();
        cyc(0, 0, 1, 0, 0, 0);  want("collect2", ST_IDLE, 0, 8); drain();

        // cancel from PAUSE keeps the money
        cyc(1, 0, 0, 0, 0, 1);  want("start_m1", ST_RUN, 2, 3); drain();
        cyc(1, 0, 0, 0, 0, 0);  want("pause2", ST_PAUSE, 2, 3); drain();
        cyc(0, 1, 0, 0, 0, 0);  want("cancel", ST_IDLE, 0, 3); drain();

        // fine clamps at zero
        cyc(0, 0, 0, 1, 3, 0);  want("credit3", ST_IDLE, 0, 6); drain();
        cyc(1, 0, 0, 0, 0, 0);  want("start_m0", ST_RUN, 1, 3); drain();
        idle(3);                want("m0_last", ST_RUN, 1, 3); drain();
        idle(1); want("m0_done", ST_DONE, 0, 3); push("m0_done.done", SG_DONE, 1); drain();
        idle(11); want("pre_clamp", ST_DONE, 0, 3); push("pre_clamp.flag", SG_FINE, 0); drain();
        idle(1);  want("clamp", ST_DONE, 0, 0); push("clamp.flag", SG_FINE, 1); drain();
        idle(13); want("clamp_once", ST_DONE, 0, 0); drain();
        cyc(0, 0, 1, 0, 0, 0);  want("collect3", ST_IDLE, 0, 0); push("collect3.flag", SG_FINE, 0); drain();

        // same-cycle credit does not fund the start
        cyc(1, 0, 0, 1, 5, 1);  want("precredit", ST_IDLE, 0, 5); push("precredit.err", SG_ERR, 1); drain();

        // saturating credit with debit
        cyc(0, 0, 0, 1, 1015, 0); want("credit1015", ST_IDLE, 0, 1020); drain();
        cyc(1, 0, 0, 1, 10, 1);   want("sat", ST_RUN, 2, 1023); drain();

        // async reset mid-RUN, visible before the next clock edge
        idle(1);
        #2 rst = 0;
        #1 want_reset("async_rst");
        @(negedge clk);
        rst = 1;
        idle(2);
        want_reset("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end");
        $fatal(1);
    end
endmodule
